// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM protocol types: bus word, RAM handshake state and arbiter state.
// Build option RAM_TIMEOUT_EN adds the FAULT arbiter state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

`ifdef RAM_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE,
        IGNT,
        DGNT,
        FAULT
    } arbstate_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        IGNT,
        DGNT
    } arbstate_t;
`endif

    localparam int unsigned WDOG_W = 16;

    // Data port has fixed priority over instruction fetch.
    function automatic arbstate_t arbitrate(input logic ireq, input logic dreq);
        if (dreq) begin
            return DGNT;
        end
        if (ireq) begin
            return IGNT;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/cpu_ram_if.sv
// Single shared RAM bus: the cpu side drives request/address/data, the ram side
// answers with load data and its handshake state.
interface cpu_ram_if;
    import cpu_types_pkg::*;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport cpu (
        output ramREN,
        output ramWEN,
        output ramaddr,
        output ramstore,
        input  ramload,
        input  ramstate
    );

    modport ram (
        input  ramREN,
        input  ramWEN,
        input  ramaddr,
        input  ramstore,
        output ramload,
        output ramstate
    );

endinterface

// File: rtl/ram_watchdog.sv
// Grant-cycle watchdog for ram_arbiter; only instantiated when RAM_TIMEOUT_EN is defined.
// Flags expiry in the TIMEOUT-th consecutive grant cycle that has not seen ACCESS.
module ram_watchdog
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic CLK,
    input  logic nRST,
    input  logic granted,
    input  logic access,
    output logic expired
);

    logic [WDOG_W-1:0] cnt;

    // A completion re-enters a grant state, so it clears the count just like idling does.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (!granted || access) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = granted & ~access & ({16'd0, cnt} >= (TIMEOUT - 32'd1));

endmodule

// File: rtl/ram_arbiter.sv
// Instruction/data arbiter in front of the shared RAM; data has fixed priority.
// Define RAM_TIMEOUT_EN to add the grant watchdog and the sticky FAULT state.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic   CLK,
    input  logic   nRST,
    input  logic   iREN,
    input  word_t  iaddr,
    output word_t  iload,
    output logic   iwait,
    input  logic   dREN,
    input  logic   dWEN,
    input  word_t  daddr,
    input  word_t  dstore,
    output word_t  dload,
    output logic   dwait,
    output logic   fault,
    cpu_ram_if.cpu ramif
);

    arbstate_t state;
    logic      ireq;
    logic      dreq;
    logic      access;

    assign ireq   = iREN;
    assign dreq   = dREN | dWEN;
    assign access = (ramif.ramstate == ACCESS);

    assign iload = ramif.ramload;
    assign dload = ramif.ramload;

`ifdef RAM_TIMEOUT_EN
    logic granted;
    logic expired;
    logic fault_q;

    assign granted = (state == IGNT) || (state == DGNT);
    assign fault   = fault_q;

    ram_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .CLK     (CLK),
        .nRST    (nRST),
        .granted (granted),
        .access  (access),
        .expired (expired)
    );
`else
    assign fault = 1'b0;
`endif

    // On completion the next grant is chosen immediately so back-to-back requests
    // see no idle cycle; a withdrawn request simply drops back to IDLE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
`ifdef RAM_TIMEOUT_EN
            fault_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: state <= arbitrate(ireq, dreq);
                IGNT: begin
                    if (access) begin
                        state <= arbitrate(ireq, dreq);
                    end else if (!ireq) begin
                        state <= IDLE;
                    end
                end
                DGNT: begin
                    if (access) begin
                        state <= arbitrate(ireq, dreq);
                    end else if (!dreq) begin
                        state <= IDLE;
                    end
                end
                default: state <= state;
            endcase
`ifdef RAM_TIMEOUT_EN
            if (expired) begin
                state   <= FAULT;
                fault_q <= 1'b1;
            end
`endif
        end
    end

    always_comb begin
        ramif.ramREN   = 1'b0;
        ramif.ramWEN   = 1'b0;
        ramif.ramaddr  = '0;
        ramif.ramstore = '0;
        iwait          = ireq;
        dwait          = dreq;
        case (state)
            IGNT: begin
                ramif.ramREN  = 1'b1;
                ramif.ramaddr = iaddr;
                iwait         = ~access;
            end
            DGNT: begin
                ramif.ramaddr  = daddr;
                ramif.ramstore = dstore;
                ramif.ramWEN   = dWEN;
                ramif.ramREN   = dREN & ~dWEN;
                dwait          = ~access;
            end
`ifdef RAM_TIMEOUT_EN
            FAULT: begin
                iwait = 1'b1;
                dwait = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: latency-programmable RAM model on the ram modport plus a
// transaction-level reference (completion cycles by formula, expected memory image).
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  iREN, dREN, dWEN;
    word_t iaddr, daddr, dstore, iload, dload;
    logic  iwait, dwait, fault;

    int unsigned total = 0;
    int unsigned bad   = 0;

    cpu_ram_if ramif ();

    ram_arbiter #(.TIMEOUT(8)) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .iREN   (iREN),
        .iaddr  (iaddr),
        .iload  (iload),
        .iwait  (iwait),
        .dREN   (dREN),
        .dWEN   (dWEN),
        .daddr  (daddr),
        .dstore (dstore),
        .dload  (dload),
        .dwait  (dwait),
        .fault  (fault),
        .ramif  (ramif.cpu)
    );

    always #5 CLK = ~CLK;

    // ---------------- RAM environment ----------------
    int unsigned lat       = 0;
    logic        hold_busy = 1'b0;
    word_t       mem [logic [29:0]];
    logic [33:0] prev_key;
    logic        prev_valid = 1'b0;
    logic        was_acc    = 1'b0;
    int unsigned rcnt       = 0;

    function automatic word_t init_val(input logic [29:0] a);
        return {a[13:0], ~a[17:0]} ^ 32'h5A5A_3C3C;
    endfunction

    function automatic word_t ram_rd(input logic [29:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    initial begin
        ramif.ramstate = FREE;
        ramif.ramload  = '0;
    end

    // New request: ACCESS after lat+1 further cycles of the same request.
    always @(negedge CLK) begin
        logic [33:0] key;
        key = {ramif.ramREN, ramif.ramWEN, ramif.ramaddr};
        ramif.ramload = ram_rd(ramif.ramaddr[31:2]);
        if (!(ramif.ramREN | ramif.ramWEN)) begin
            rcnt = 0; prev_valid = 1'b0; was_acc = 1'b0;
            ramif.ramstate = FREE;
        end else begin
            if (prev_valid && key == prev_key && !was_acc) rcnt++;
            else rcnt = 0;
            prev_key = key; prev_valid = 1'b1;
            if (!hold_busy && rcnt == lat + 1) begin
                ramif.ramstate = ACCESS;
                was_acc = 1'b1;
                if (ramif.ramWEN) mem[ramif.ramaddr[31:2]] = ramif.ramstore;
            end else begin
                ramif.ramstate = BUSY;
                was_acc = 1'b0;
            end
        end
    end

    // ---------------- reference memory image ----------------
    word_t model_mem [logic [29:0]];

    function automatic word_t exp_rd(input word_t a);
        return model_mem.exists(a[31:2]) ? model_mem[a[31:2]] : init_val(a[31:2]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction; the requester drops a request in the same cycle its wait is low.
    task automatic run_txn(input bit doi, input bit dod, input bit dwr,
                           input word_t ia, input word_t da, input word_t ds,
                           input int unsigned L);
        int unsigned icyc = 999, dcyc = 999, istart;
        bit ipend = doi, dpend = dod;
        lat = L;
        istart = dod ? L + 3 : 1;
        @(posedge CLK); #1;
        iREN = doi; iaddr = ia;
        dREN = dod & ~dwr; dWEN = dod & dwr; daddr = da; dstore = ds;
        for (int c = 0; c < 40 && (ipend || dpend); c++) begin
            @(negedge CLK); #1;
            check("excl", {31'd0, ramif.ramREN & ramif.ramWEN}, 32'd0);
            if (c == 0) check("grant_reg", {30'd0, ramif.ramREN, ramif.ramWEN}, 32'd0);
            if (dpend && c >= 1) begin
                check("d_addr", ramif.ramaddr, da);
                check("d_en", {30'd0, ramif.ramREN, ramif.ramWEN}, {30'd0, ~dwr, dwr});
            end
            if (ipend && !dpend && c >= istart) begin
                check("i_addr", ramif.ramaddr, ia);
                check("i_en", {30'd0, ramif.ramREN, ramif.ramWEN}, 32'd2);
            end
            if (dpend && !dwait) begin
                dcyc = c; dpend = 0;
                if (dwr) model_mem[da[31:2]] = ds;
                else check("dload", dload, exp_rd(da));
                dREN = 1'b0; dWEN = 1'b0;
            end
            if (ipend && !iwait) begin
                icyc = c; ipend = 0;
                check("iload", iload, exp_rd(ia));
                iREN = 1'b0;
            end
        end
        if (dod) check("d_cycles", dcyc, L + 2);
        if (doi) check("i_cycles", icyc, dod ? 2 * L + 4 : L + 2);
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        #12;
        check("rst_iwait", {31'd0, iwait}, 32'd1);
        check("rst_dwait", {31'd0, dwait}, 32'd0);
        check("rst_en", {30'd0, ramif.ramREN, ramif.ramWEN}, 32'd0);
        check("rst_addr", ramif.ramaddr, 32'd0);
        check("rst_store", ramif.ramstore, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        dWEN = 1'b1; #1;
        check("rst_dwait_req", {31'd0, dwait}, 32'd1);
        iREN = 1'b0; dWEN = 1'b0;
        @(posedge CLK); #1; nRST = 1'b1;

        // single data read
        mem[30'h40] = 32'hDEADBEEF; model_mem[30'h40] = 32'hDEADBEEF;
        run_txn(0, 1, 0, 32'h0, 32'h100, 32'h0, 0);

        // simultaneous instruction read and data write
        run_txn(1, 1, 1, 32'h0, 32'h40, 32'h12345678, 0);
        check("sim_mem", mem.exists(30'h10) ? mem[30'h10] : 32'hX, 32'h12345678);

        // latency sweep
        run_txn(1, 0, 0, 32'h8, 32'h0, 32'h0, 0);
        run_txn(1, 0, 0, 32'h8, 32'h0, 32'h0, 1);
        run_txn(1, 0, 0, 32'h8, 32'h0, 32'h0, 3);

        // withdrawal during the grant
        lat = 3;
        @(posedge CLK); #1; dREN = 1'b1; daddr = 32'h200;
        @(negedge CLK); #1;
        @(negedge CLK); #1;
        check("wd_ren", {31'd0, ramif.ramREN}, 32'd1);
        check("wd_dwait", {31'd0, dwait}, 32'd1);
        dREN = 1'b0;
        @(negedge CLK); #1;
        check("wd_idle_ren", {31'd0, ramif.ramREN}, 32'd0);
        check("wd_idle_addr", ramif.ramaddr, 32'd0);
        check("wd_dwait_lo", {31'd0, dwait}, 32'd0);

        // asynchronous reset in the middle of a data grant
        lat = 3;
        @(posedge CLK); #1; dWEN = 1'b1; daddr = 32'h40; dstore = 32'hCAFEF00D;
        @(posedge CLK); #1;
        check("rst_pre_wen", {31'd0, ramif.ramWEN}, 32'd1);
        nRST = 1'b0; #1;
        check("rst_mid_wen", {31'd0, ramif.ramWEN}, 32'd0);
        check("rst_mid_addr", ramif.ramaddr, 32'd0);
        check("rst_mid_dwait", {31'd0, dwait}, 32'd1);
        dWEN = 1'b0;
        @(posedge CLK); #1; nRST = 1'b1;
        run_txn(0, 1, 0, 32'h0, 32'h40, 32'h0, 0);
        run_txn(0, 1, 1, 32'h0, 32'h40, 32'hA5A50F0F, 1);
        run_txn(0, 1, 0, 32'h0, 32'h40, 32'h0, 2);

        // RAM stuck BUSY
        hold_busy = 1'b1; lat = 0;
        @(posedge CLK); #1; dREN = 1'b1; daddr = 32'h80;
        for (int c = 0; c <= 20; c++) begin
            @(negedge CLK); #1;
`ifdef RAM_TIMEOUT_EN
            check("to_fault", {31'd0, fault}, {31'd0, c >= 9});
            if (c >= 9) begin
                check("to_dwait", {31'd0, dwait}, 32'd1);
                check("to_iwait", {31'd0, iwait}, 32'd1);
            end
`else
            check("to_fault", {31'd0, fault}, 32'd0);
            check("to_dwait", {31'd0, dwait}, 32'd1);
`endif
        end
        dREN = 1'b0; hold_busy = 1'b0;
        @(posedge CLK); #1; nRST = 1'b0;
        @(posedge CLK); #1; nRST = 1'b1;
        check("post_fault", {31'd0, fault}, 32'd0);

        // randomized mix of transactions over a small address pool
        for (int n = 0; n < 40; n++) begin
            int unsigned k, L;
            word_t ia, da, ds;
            k  = $urandom_range(0, 4);
            L  = $urandom_range(0, 3);
            ia = word_t'($urandom_range(0, 15)) << 2;
            da = word_t'($urandom_range(0, 15)) << 2;
            ds = $urandom;
            case (k)
                0: run_txn(1, 0, 0, ia, da, ds, L);
                1: run_txn(0, 1, 0, ia, da, ds, L);
                2: run_txn(0, 1, 1, ia, da, ds, L);
                3: run_txn(1, 1, 0, ia, da, ds, L);
                default: run_txn(1, 1, 1, ia, da, ds, L);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
